// File: rtl/mdu_unit_if.sv
// mdu_unit_if: operand/control/result bundle between EX and the MDU.
// The EX stage (master) drives operands; the MDU (slave) returns HI/LO state.
interface mdu_unit_if;
    logic [31:0] MDU_Operand1;
    logic [31:0] MDU_Operand2;
    logic [3:0]  MDU_Operation;
    logic        MDU_Start;
    logic        MDU_ReadHi;
    logic [31:0] MDU_Result;
    logic        MDU_Busy;
    logic [31:0] MDU_HI;
    logic [31:0] MDU_LO;

    modport master (
        output MDU_Operand1,
        output MDU_Operand2,
        output MDU_Operation,
        output MDU_Start,
        output MDU_ReadHi,
        input  MDU_Result,
        input  MDU_Busy,
        input  MDU_HI,
        input  MDU_LO
    );

    modport slave (
        input  MDU_Operand1,
        input  MDU_Operand2,
        input  MDU_Operation,
        input  MDU_Start,
        input  MDU_ReadHi,
        output MDU_Result,
        output MDU_Busy,
        output MDU_HI,
        output MDU_LO
    );
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: EX-stage multiply/divide unit owning HI/LO, fixed latency.
// Optional MADD/MADDU/MSUB accumulate ops enabled by `define MDU_MADD_EN.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset_n,
    mdu_unit_if.slave  mdu
);
    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

    localparam logic [3:0] MUL_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] sl_q, sl_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;
`ifdef MDU_MADD_EN
    logic        acc_q, acc_d;
    logic        sub_q, sub_d;
    logic        is_acc, is_sub;
    logic [63:0] acc_sum;
`endif

    logic        is_mul, is_div;
    logic        mul_sgn, div_sgn;
    logic        accept, done;
    logic [31:0] a, b;
    logic [63:0] a64, b64, prod;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div;
    logic [31:0] uq, ur, quo, rem;
    logic [63:0] res;

    assign a = mdu.MDU_Operand1;
    assign b = mdu.MDU_Operand2;

    // Decode the requested operation class
    always_comb begin
        is_mul  = 1'b0;
        is_div  = 1'b0;
        mul_sgn = 1'b0;
        div_sgn = 1'b0;
`ifdef MDU_MADD_EN
        is_acc  = 1'b0;
        is_sub  = 1'b0;
`endif
        case (mdu.MDU_Operation)
            OP_MULT:  begin is_mul = 1'b1; mul_sgn = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; div_sgn = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin
                is_mul = 1'b1; mul_sgn = 1'b1; is_acc = 1'b1;
            end
            OP_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
            OP_MSUB:  begin
                is_mul = 1'b1; mul_sgn = 1'b1;
                is_acc = 1'b1; is_sub = 1'b1;
            end
`endif
            default:  ;
        endcase
    end

    // Full-width product and sign-magnitude divide, computed in one cycle
    always_comb begin
        a64   = mul_sgn ? {{32{a[31]}}, a} : {32'd0, a};
        b64   = mul_sgn ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = a64 * b64;
        a_neg = div_sgn & a[31];
        b_neg = div_sgn & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        // Zero divisor is replaced to keep the datapath defined; result dropped
        b_div = (b == 32'd0) ? 32'd1 : b_mag;
        uq    = a_mag / b_div;
        ur    = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem   = a_neg ? (32'd0 - ur) : ur;
        res   = is_div ? {rem, quo} : prod;
    end

    assign accept = (state_q == IDLE) && mdu.MDU_Start && (is_mul || is_div);
    assign done   = (state_q == RUN) && (cnt_q == 4'd1);

`ifdef MDU_MADD_EN
    assign acc_sum = sub_q ? ({hi_q, lo_q} - {sh_q, sl_q})
                           : ({hi_q, lo_q} + {sh_q, sl_q});
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: launch, countdown, commit and MTHI/MTLO
    always_comb begin
        cnt_d = cnt_q;
        sh_d  = sh_q;
        sl_d  = sl_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        dz_d  = dz_q;
`ifdef MDU_MADD_EN
        acc_d = acc_q;
        sub_d = sub_q;
`endif
        if (accept) begin
            cnt_d = is_div ? DIV_LAT : MUL_LAT;
            sh_d  = res[63:32];
            sl_d  = res[31:0];
            dz_d  = is_div && (b == 32'd0);
`ifdef MDU_MADD_EN
            acc_d = is_acc;
            sub_d = is_sub;
`endif
        end else if ((state_q == IDLE) && mdu.MDU_Start) begin
            if (mdu.MDU_Operation == OP_MTHI) hi_d = a;
            if (mdu.MDU_Operation == OP_MTLO) lo_d = a;
        end
        if (state_q == RUN) begin
            if (done) begin
                cnt_d = 4'd0;
                if (!dz_q) begin
`ifdef MDU_MADD_EN
                    if (acc_q) begin
                        hi_d = acc_sum[63:32];
                        lo_d = acc_sum[31:0];
                    end else begin
                        hi_d = sh_q;
                        lo_d = sl_q;
                    end
`else
                    hi_d = sh_q;
                    lo_d = sl_q;
`endif
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // Datapath registers; reset discards any in-flight shadow result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
            sh_q  <= 32'd0;
            sl_q  <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            dz_q  <= 1'b0;
`ifdef MDU_MADD_EN
            acc_q <= 1'b0;
            sub_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
            sl_q  <= sl_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dz_q  <= dz_d;
`ifdef MDU_MADD_EN
            acc_q <= acc_d;
            sub_q <= sub_d;
`endif
        end
    end

    // Outputs: committed HI/LO only, never the shadow registers
    always_comb begin
        mdu.MDU_Result = mdu.MDU_ReadHi ? hi_q : lo_q;
        mdu.MDU_Busy   = (state_q == RUN);
        mdu.MDU_HI     = hi_q;
        mdu.MDU_LO     = lo_q;
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench for mdu_unit with a plain-arithmetic model.
// Directed cases from the plan plus randomized operation sequences.
module tb_mdu_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mdu_unit_if bus();

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mdu(bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules
    task automatic model_op(input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi_i, input logic [31:0] lo_i,
                            output logic [31:0] hi_o, output logic [31:0] lo_o,
                            output int lat);
        logic signed [63:0] sa, sb2, q, r, p;
        logic [63:0] u, acc;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        hi_o = hi_i;
        lo_o = lo_i;
        lat = 0;
        acc = {hi_i, lo_i};
        case (op)
            4'd1: begin p = sa * sb2; {hi_o, lo_o} = p; lat = 5; end
            4'd2: begin
                u = {32'd0, a} * {32'd0, b};
                {hi_o, lo_o} = u; lat = 5;
            end
            4'd3: begin
                lat = 10;
                if (b != 0) begin
                    q = sa / sb2; r = sa % sb2;
                    lo_o = q[31:0]; hi_o = r[31:0];
                end
            end
            4'd4: begin
                lat = 10;
                if (b != 0) begin lo_o = a / b; hi_o = a % b; end
            end
            4'd5: hi_o = a;
            4'd6: lo_o = a;
`ifdef MDU_MADD_EN
            4'd7: begin p = sa * sb2; {hi_o, lo_o} = acc + p; lat = 5; end
            4'd8: begin
                u = {32'd0, a} * {32'd0, b};
                {hi_o, lo_o} = acc + u; lat = 5;
            end
            4'd9: begin p = sa * sb2; {hi_o, lo_o} = acc - p; lat = 5; end
`endif
            default: ;
        endcase
    endtask

    // Monitor: on each busy->idle transition pop and compare the scoreboard
    bit prev_busy = 0;
    int bcnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_busy = 0;
            bcnt = 0;
        end else begin
            if (bus.MDU_Busy) begin
                bcnt++;
            end else if (prev_busy) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_completion: got busy end, required none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.MDU_HI !== e.hi || bus.MDU_LO !== e.lo
                        || bcnt != e.lat) begin
                        n_err++;
                        $display("FAIL %s: got hi=%h lo=%h busy=%0d required hi=%h lo=%h busy=%0d",
                                 e.tag, bus.MDU_HI, bus.MDU_LO, bcnt,
                                 e.hi, e.lo, e.lat);
                    end
                end
                bcnt = 0;
            end
            prev_busy = bus.MDU_Busy;
        end
    end

    // Drive one started op at a negedge; returns at the negedge after accept
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.MDU_Operation = op;
        bus.MDU_Operand1 = a;
        bus.MDU_Operand2 = b;
        bus.MDU_Start = 1'b1;
        @(negedge clk);
        bus.MDU_Start = 1'b0;
        bus.MDU_Operation = 4'd0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!bus.MDU_Busy) break;
            @(negedge clk);
        end
        chk("idle_timeout", {31'd0, bus.MDU_Busy}, 32'd0);
    endtask

    // Issue op, update model; long ops go to the scoreboard
    task automatic start_op(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input string tag,
                            output int lat);
        logic [31:0] nh, nl;
        exp_t e;
        model_op(op, a, b, m_hi, m_lo, nh, nl, lat);
        if (lat != 0) begin
            e.hi = nh; e.lo = nl; e.lat = lat; e.tag = tag;
            sb.push_back(e);
        end
        issue(op, a, b);
        m_hi = nh;
        m_lo = nl;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int lat;
        start_op(op, a, b, tag, lat);
        if (lat != 0) begin
            wait_idle();
        end else begin
            chk({tag, "_busy"}, {31'd0, bus.MDU_Busy}, 32'd0);
            chk({tag, "_hi"}, bus.MDU_HI, m_hi);
            chk({tag, "_lo"}, bus.MDU_LO, m_lo);
        end
    endtask

    task automatic chk_hilo(input string nm, input logic [31:0] h,
                            input logic [31:0] l);
        chk({nm, "_hi"}, bus.MDU_HI, h);
        chk({nm, "_lo"}, bus.MDU_LO, l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0] ops[$];
        bus.MDU_Operand1 = 0;
        bus.MDU_Operand2 = 0;
        bus.MDU_Operation = 0;
        bus.MDU_Start = 0;
        bus.MDU_ReadHi = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.MDU_Busy}, 32'd0);
        chk_hilo("rst", 32'd0, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_result", bus.MDU_Result, 32'd0);

        run_op(4'd1, 32'hFFFFFFFF, 32'h2, "mult_m1x2");
        chk_hilo("mult_m1x2_k", 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op(4'd2, 32'hFFFFFFFF, 32'h2, "multu_m1x2");
        chk_hilo("multu_k", 32'h1, 32'hFFFFFFFE);
        run_op(4'd3, 32'hFFFFFFF9, 32'h2, "div_m7_2");
        chk_hilo("div_m7_2_k", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(4'd4, 32'd7, 32'd2, "divu_7_2");
        chk_hilo("divu_k", 32'd1, 32'd3);

        run_op(4'd5, 32'h12345678, 32'h0, "mthi");
        run_op(4'd6, 32'hCAFEBABE, 32'h0, "mtlo");
        start_op(4'd1, 32'd3, 32'd4, "mult_3x4", lat);
        issue(4'd3, 32'd9, 32'd0);
        chk("ignored_busy", {31'd0, bus.MDU_Busy}, 32'd1);
        chk_hilo("ignored_old", 32'h12345678, 32'hCAFEBABE);
        wait_idle();
        chk_hilo("mult_3x4_k", 32'd0, 32'd12);
        run_op(4'd3, 32'd9, 32'd0, "div_by_zero");
        chk_hilo("div0_k", 32'd0, 32'd12);

        start_op(4'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf", lat);
        for (int i = 0; i < 4; i++) begin
            bus.MDU_ReadHi = i[0];
            #1;
            chk("readhi_run", bus.MDU_Result, i[0] ? 32'd0 : 32'd12);
            @(negedge clk);
        end
        bus.MDU_ReadHi = 0;
        wait_idle();
        chk_hilo("div_ovf_k", 32'd0, 32'h80000000);
        bus.MDU_ReadHi = 1;
        #1 chk("result_hi", bus.MDU_Result, 32'd0);
        bus.MDU_ReadHi = 0;
        #1 chk("result_lo", bus.MDU_Result, 32'h80000000);

        run_op(4'd5, 32'hA5A5A5A5, 32'h0, "mthi2");
        start_op(4'd1, 32'd5, 32'd5, "mult_rst", lat);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.MDU_Busy}, 32'd0);
        chk_hilo("abort", 32'd0, 32'd0);
        sb.delete();
        m_hi = 0;
        m_lo = 0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_late_busy", {31'd0, bus.MDU_Busy}, 32'd0);
        chk_hilo("abort_late", 32'd0, 32'd0);

`ifdef MDU_MADD_EN
        run_op(4'd5, 32'd0, 32'd0, "mthi0");
        run_op(4'd6, 32'hFFFFFFFF, 32'd0, "mtlo_ff");
        run_op(4'd8, 32'd1, 32'd1, "maddu");
        chk_hilo("maddu_k", 32'd1, 32'd0);
        run_op(4'd9, 32'd2, 32'd3, "msub");
        chk_hilo("msub_k", 32'd0, 32'hFFFFFFFA);
`endif

        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                4'd7, 4'd8, 4'd9, 4'd12, 4'd15};
        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, ops.size() - 1)];
            a = $urandom();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            run_op(op, a, b, $sformatf("rand%0d_op%0d", n, op));
        end

        repeat (2) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage, fed by the same forwarded operands as the ALU.
- Owns architectural HI/LO. Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and services MTHI/MTLO writes.
- Provides the HI/LO read value that the EX result mux selects in place of the ALU result for MFHI/MFLO.
- Exports a busy flag; the hazard unit uses it to stall ID.

Parameters:
- MULT_CYCLES, 5, cycles from start acceptance to HI/LO update for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, cycles from start acceptance to HI/LO update for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- MDU_Operand1  input  32  rs value, already forwarded.
- MDU_Operand2  input  32  rt value, already forwarded.
- MDU_Operation  input  4  0:NOP 1:MULT 2:MULTU 3:DIV 4:DIVU 5:MTHI 6:MTLO; 7-9 reserved for the optional feature; others are treated as NOP.
- MDU_Start  input  1  one-cycle qualifier for MDU_Operation.
- MDU_ReadHi  input  1  1 selects HI onto MDU_Result, 0 selects LO.
- MDU_Result  output  32  combinational read of the current committed HI or LO.
- MDU_Busy  output  1  high while an operation is in flight.
- MDU_HI  output  32  committed HI, for debug.
- MDU_LO  output  32  committed LO, for debug.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low.
- Reset values: HI=0, LO=0, MDU_Busy=0, counter=0, state=IDLE.
- FSM states: IDLE, RUN.
- IDLE, accepting MDU_Start with MULT/MULTU/DIV/DIVU:
  - Compute the full result in the same cycle.
  - Latch it into shadow regs SH/SL.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Next state is RUN. MDU_Busy goes high on the next edge.
- RUN:
  - The counter decrements each cycle.
  - On the edge where counter==1: HI<=SH, LO<=SL, Busy<=0, next state is IDLE.
  - Total latency: HI/LO are visible exactly N cycles after the accepting edge.
- MTHI/MTLO in IDLE: HI or LO <= MDU_Operand1 on that edge. Busy is not asserted.
- MDU_Start while Busy=1 is ignored: no state change, no HI/LO write. The hazard unit must stall ID on (MDU_Busy | MDU_Start&&isMDUop).
- MFHI/MFLO are never blocked by the MDU. MDU_Result always shows committed HI/LO, never the shadow regs.
- MULT: signed 32x32 to 64, {HI,LO}=product.
- MULTU: unsigned 32x32 to 64, {HI,LO}=product.
- DIV (signed):
  - LO=quotient, truncated toward zero; HI=remainder, sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (Operand2==0): the operation still runs full DIV_CYCLES with Busy high; HI and LO stay unchanged at completion.
- reset_n low mid-operation: abort immediately; all state returns to reset values; the shadow result is discarded.
- NOP or an undefined op with Start: no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 7:MADD, 8:MADDU, 9:MSUB (signed) are legal.
  - Each uses MULT_CYCLES latency.
  - At completion {HI,LO} <= {HI,LO} ± product, taking the HI/LO value at the completion edge, mod 2^64.
- Undefined: codes 7-9 are NOP, and no accumulate logic is synthesized.

Test Plan:
- Reset, then MULT 0xFFFFFFFF x 0x00000002 -> Busy high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFE at cycle 5; MULTU on the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU 7/2 -> LO=3, HI=1.
- MTHI 0x12345678, then MTLO 0xCAFEBABE, then MULT 3x4 started and a new Start DIV 9/0 issued while busy -> second start ignored; final HI=0, LO=12; afterwards DIV 9/0 alone -> HI/LO unchanged after 10 busy cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; MDU_ReadHi toggled during RUN -> MDU_Result shows the old committed values until completion.
- MULT 5x5 started, reset_n pulsed low at cycle 2 -> Busy=0, HI=LO=0 immediately; no late write afterwards.
- With MDU_MADD_EN defined: MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1x1 -> HI=1, LO=0; MSUB 2x3 -> {HI,LO}=0x00000000_FFFFFFFA.
